// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default widths for the memory bus arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_WRESP
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of cache-side and memory-side signals around the arbiter.
// master: the arbiter's view; slave: the caches plus bus bridge.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W,
  parameter int LEN_W  = mem_arb_pkg::LEN_W
);
  // I-cache side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [LEN_W-1:0]  i_len;
  logic              i_gnt;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rvalid;
  logic              i_rlast;
  // D-cache side
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [LEN_W-1:0]  d_len;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_wready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  logic              d_rlast;
  logic              d_bdone;
  // Memory bus side
  logic              m_req;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [LEN_W-1:0]  m_len;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rvalid;
  logic              m_rlast;
  logic [DATA_W-1:0] m_wdata;
  logic              m_wvalid;
  logic              m_wlast;
  logic              m_wready;
  logic              m_bvalid;

  modport master (
    input  i_req, i_addr, i_len,
    output i_gnt, i_rdata, i_rvalid, i_rlast,
    input  d_req, d_wr, d_addr, d_len, d_wdata,
    output d_gnt, d_wready, d_rdata, d_rvalid, d_rlast, d_bdone,
    output m_req, m_wr, m_addr, m_len, m_wdata, m_wvalid, m_wlast,
    input  m_ack, m_rdata, m_rvalid, m_rlast, m_wready, m_bvalid
  );

  modport slave (
    output i_req, i_addr, i_len,
    input  i_gnt, i_rdata, i_rvalid, i_rlast,
    output d_req, d_wr, d_addr, d_len, d_wdata,
    input  d_gnt, d_wready, d_rdata, d_rvalid, d_rlast, d_bdone,
    input  m_req, m_wr, m_addr, m_len, m_wdata, m_wvalid, m_wlast,
    output m_ack, m_rdata, m_rvalid, m_rlast, m_wready, m_bvalid
  );

endinterface

// File: rtl/mem_bus_arbiter_pick.sv
// Winner select between I-cache and D-cache requests.
// Default: fixed D-over-I priority. With ARB_RR_EN defined, a 1-bit
// last-owner register alternates priority on simultaneous requests.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   take,     // a grant is issued this cycle
`endif
  input  logic   i_req,
  input  logic   d_req,
  output owner_e winner
);

`ifdef ARB_RR_EN
  logic last_d_q;  // 1: D owned the bus last; resets to I so D wins the first tie

  // Remember who was granted most recently.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else if (take) begin
      last_d_q <= (winner == OWN_D);
    end
  end

  // Lone requester wins; on a tie the one that did not own last wins.
  // NOTE: the default is assigned first so no path through the block leaves winner unassigned (no latch).
  always_comb begin
    winner = OWN_NONE;
    if (d_req && i_req) winner = last_d_q ? OWN_I : OWN_D;
    else if (d_req)     winner = OWN_D;
    else if (i_req)     winner = OWN_I;
  end
`else
  // Fixed priority: D over I; I may starve under continuous D traffic.
  always_comb begin
    winner = OWN_NONE;
    if (d_req)      winner = OWN_D;
    else if (i_req) winner = OWN_I;
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between the I-cache refill path and the
// D-cache refill/writeback path, one transaction at a time.
// Optional macro ARB_RR_EN: round-robin between simultaneous requests.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W,
  parameter int LEN_W  = mem_arb_pkg::LEN_W
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.master bus
);

  state_e            state_q, state_d;
  owner_e            owner_q, winner;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              wr_q;
  logic              load;
  logic              wlast;

  mem_arb_pick u_pick (
`ifdef ARB_RR_EN
    .clk    (clk),
    .rst    (rst),
    .take   (load),
`endif
    .i_req  (bus.i_req),
    .d_req  (bus.d_req),
    .winner (winner)
  );

  // Latched address-phase fields are presented for the whole transaction.
  assign bus.m_addr = addr_q;
  assign bus.m_len  = len_q;
  assign bus.m_wr   = wr_q;

  // State, beat counter and latched request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        owner_q <= winner;
        addr_q  <= (winner == OWN_D) ? bus.d_addr : bus.i_addr;
        len_q   <= (winner == OWN_D) ? bus.d_len  : bus.i_len;
        wr_q    <= (winner == OWN_D) ? bus.d_wr   : 1'b0;
      end
    end
  end

  // Next state, grants and per-state routing of bus handshakes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load         = 1'b0;
    wlast        = 1'b0;
    bus.i_gnt    = 1'b0;
    bus.i_rdata  = '0;
    bus.i_rvalid = 1'b0;
    bus.i_rlast  = 1'b0;
    bus.d_gnt    = 1'b0;
    bus.d_wready = 1'b0;
    bus.d_rdata  = '0;
    bus.d_rvalid = 1'b0;
    bus.d_rlast  = 1'b0;
    bus.d_bdone  = 1'b0;
    bus.m_req    = 1'b0;
    bus.m_wdata  = '0;
    bus.m_wvalid = 1'b0;
    bus.m_wlast  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Grants are combinational, but never while reset is asserted.
        if (!rst && winner != OWN_NONE) begin
          load    = 1'b1;
          state_d = ST_ADDR;
          if (winner == OWN_D) bus.d_gnt = 1'b1;
          else                 bus.i_gnt = 1'b1;
        end
      end
      ST_ADDR: begin
        bus.m_req = 1'b1;
        if (bus.m_ack) begin
          cnt_d   = '0;
          state_d = wr_q ? ST_WDATA : ST_RDATA;
        end
      end
      ST_RDATA: begin
        // Read data is shared; only the owner sees valid/last. m_rlast ends the burst.
        bus.i_rdata = bus.m_rdata;
        bus.d_rdata = bus.m_rdata;
        if (owner_q == OWN_D) begin
          bus.d_rvalid = bus.m_rvalid;
          bus.d_rlast  = bus.m_rlast;
        end else begin
          bus.i_rvalid = bus.m_rvalid;
          bus.i_rlast  = bus.m_rlast;
        end
        if (bus.m_rvalid && bus.m_rlast) state_d = ST_IDLE;
      end
      ST_WDATA: begin
        wlast        = (cnt_q == len_q);
        bus.m_wvalid = 1'b1;
        bus.m_wdata  = bus.d_wdata;
        bus.m_wlast  = wlast;
        bus.d_wready = bus.m_wready;
        if (bus.m_wready) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (wlast) state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (bus.m_bvalid) begin
          bus.d_bdone = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
